rv_pipe_buffer: RTL
===================

Name: rv_pipe_buffer

Overview:
- Parametrised ready/valid buffer that replaces the single-shot handshake register with a DEPTH-entry FIFO.
- Full-throughput: one beat per cycle, with back-pressure to the producer and a per-beat tx_done pulse.
- Sits between a data producer (e.g. operand fetch) and a consumer (e.g. systolic array feeder).
- Decouples their stall timing without a combinational ready path.

Parameters:
- WIDTH, 64, data width in bits (>=1).
- DEPTH, 4, number of storage entries; power of two, >=2.
- LW, $clog2(DEPTH+1), width of the level output (derived; not overridden).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- flush  input  1  synchronous clear of all stored beats.
- in_valid  input  1  producer has a beat on in_data.
- in_ready  output  1  buffer can accept a beat this cycle.
- in_data  input  WIDTH  producer data.
- out_valid  output  1  a beat is presented on out_data.
- out_ready  input  1  consumer accepts the presented beat.
- out_data  output  WIDTH  head-of-buffer data.
- tx_done  output  1  one-cycle pulse, one cycle after each accepted input beat.
- level  output  LW  number of stored beats, 0..DEPTH.

Behaviour:
- Handshake definitions: push = in_valid & in_ready; pop = out_valid & out_ready. Both are sampled on the rising clk edge.
- in_ready = (level != DEPTH) & ~flush. It depends only on registered state and flush; there is no path from out_ready.
- out_valid = (level != 0). out_data = storage[rd_ptr], read combinationally from registers.
- Data is stable while out_valid=1 and out_ready=0; the producer must hold in_data while in_valid=1 and in_ready=0.
- Latency: a beat pushed at edge N is visible with out_valid=1 after edge N (one-cycle latency). There is no bypass when empty.
- Pointers: wr_ptr and rd_ptr are $clog2(DEPTH) bits wide and wrap naturally from DEPTH-1 to 0. Level is tracked explicitly, not derived from pointers.
- Level update per edge:
  - push only: level+1.
  - pop only: level-1.
  - push & pop: unchanged, both pointers advance.
  - neither: unchanged.
- Full (level=DEPTH): in_ready=0, so no push. A pop that cycle frees an entry; in_ready rises the next cycle.
- Empty (level=0): out_valid=0, so a pop is impossible. A push that cycle yields out_valid=1 the next cycle.
- Simultaneous push & pop at level=1: the head is replaced by the new beat, level stays 1, and order is preserved.
- flush=1 at an edge:
  - wr_ptr, rd_ptr and level go to 0.
  - Any push or pop in that cycle is discarded; in_ready is already 0.
  - tx_done is 0 in the following cycle.
  - Storage contents are not cleared.
- tx_done: a register loaded with push every cycle, so it goes high exactly one cycle after each accepted beat. Back-to-back pushes give a continuous high.
- Reset (asynchronous, reset=0):
  - pointers=0, level=0, tx_done=0, all storage entries=0.
  - Resulting outputs: out_valid=0, out_data=0, in_ready=1.
- Reset mid-operation discards all stored beats immediately, without waiting for a clock edge.
- Overflow and underflow are impossible by construction. Storage is written only on push and the read pointer moves only on pop.

Optional Feature:
- Macro: RV_XFER_CNT_EN.
- Defined:
  - Adds output port xfer_count [31:0], counting output-side transfers (pops).
  - The count increments by 1 on each pop and wraps 0xFFFFFFFF to 0.
  - It is cleared to 0 by reset; it is not cleared by flush.
  - A pop discarded by flush is not counted.
- Undefined: the port and the counter are absent. All other behaviour is identical.

Test Plan:
- Reset then idle:
  - Hold reset=0 for 3 cycles, release.
  - Required: in_ready=1, out_valid=0, level=0, tx_done=0, out_data=0.
- Fill to full (WIDTH=64, DEPTH=4):
  - Push 0xA0..0xA3 on 4 consecutive edges with out_ready=0.
  - Required: level steps 1,2,3,4; tx_done high for 4 cycles starting one cycle after the first push; in_ready=0 at level 4; a 5th beat 0xA4 with in_valid held is not accepted.
- Drain in order:
  - From the full state, set out_ready=1.
  - Required: out_data reads 0xA0,0xA1,0xA2,0xA3 on consecutive cycles; level 3,2,1,0; in_ready=1 one cycle after the first pop; out_valid=0 after the 4th pop.
- Streaming and wrap-around:
  - Hold in_valid=1 and out_ready=1 for 12 cycles with data 0..11.
  - Required: level stays 1 after the first edge; output sequence 0..11 with no gaps; pointers wrap 3 times.
- Flush and reset mid-operation:
  - With level=3, pulse flush=1 while in_valid=1 carries 0x55. Required: level=0, out_valid=0, and 0x55 is never output.
  - Refill with 2 beats, then assert reset=0 asynchronously mid-cycle. Required: level=0 and out_valid=0 immediately, before the next edge.
- RV_XFER_CNT_EN defined:
  - Perform 7 pops, then flush, then 2 pops.
  - Required: xfer_count=9 (flush does not clear it); after reset, xfer_count=0.

Source files
------------

// File: rtl/rv_pipe_buffer.sv
// rv_pipe_buffer: DEPTH-entry ready/valid FIFO with registered ready and tx_done.
// Optional pop counter output xfer_count enabled by `define RV_XFER_CNT_EN.
module rv_pipe_buffer #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4,
  parameter int LW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             tx_done,
  output logic [LW-1:0]    level
`ifdef RV_XFER_CNT_EN
  ,
  output logic [31:0]      xfer_count
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [LW-1:0] FULL = LW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push;
  logic             pop;

  // ready never looks at out_ready: no comb path through the buffer
  assign in_ready  = (level != FULL) & ~flush;
  assign out_valid = (level != '0);
  assign out_data  = mem[rd_ptr];
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready & ~flush;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (push) begin
      mem[wr_ptr] <= in_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) tx_done <= 1'b0;
    else        tx_done <= push;
  end

`ifdef RV_XFER_CNT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)   xfer_count <= '0;
    else if (pop) xfer_count <= xfer_count + 32'd1;
  end
`endif

endmodule
